// File: rtl/move_sequencer_pkg.sv
// Shared move definitions for the cube robot: move codes, code width, legality check and the
// state encodings used by move_sequencer.
package rbot_move_defs;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] MOVE_NOP = 4'd0;
  localparam logic [CODE_W-1:0] MOVE_R   = 4'd2;
  localparam logic [CODE_W-1:0] MOVE_RI  = 4'd3;
  localparam logic [CODE_W-1:0] MOVE_U   = 4'd4;
  localparam logic [CODE_W-1:0] MOVE_UI  = 4'd5;
  localparam logic [CODE_W-1:0] MOVE_F   = 4'd6;
  localparam logic [CODE_W-1:0] MOVE_FI  = 4'd7;
  localparam logic [CODE_W-1:0] MOVE_L   = 4'd8;
  localparam logic [CODE_W-1:0] MOVE_LI  = 4'd9;
  localparam logic [CODE_W-1:0] MOVE_B   = 4'd10;
  localparam logic [CODE_W-1:0] MOVE_BI  = 4'd11;
  localparam logic [CODE_W-1:0] MOVE_D   = 4'd12;
  localparam logic [CODE_W-1:0] MOVE_DI  = 4'd13;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ALIGN     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_SETTLE    = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Codes 1, 14 and 15 are not face turns and must never reach the motor driver.
  function automatic logic is_legal_code(input logic [CODE_W-1:0] code);
    return (code >= MOVE_R) && (code <= MOVE_DI);
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Move handshake between the sequencer (master) and the face-turn motor driver (slave).
interface move_sequencer_if;
  import rbot_move_defs::*;

  logic              move_valid;
  logic [CODE_W-1:0] move_code;
  logic              move_ready;
  logic              motor_done;

  modport master (
    output move_valid,
    output move_code,
    input  move_ready,
    input  motor_done
  );

  modport slave (
    input  move_valid,
    input  move_code,
    output move_ready,
    output motor_done
  );

endinterface

// File: rtl/move_sequencer_settle_timer.sv
// Post-move settle timer: load on motor_done, count down while enabled, flag expiry.
// Only compiled and used when MOVE_SETTLE_EN is defined.
`ifdef MOVE_SETTLE_EN
module settle_timer #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    // Loading CYCLES-1 makes expiry land on the last of exactly CYCLES enabled cycles.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(CYCLES - 1);
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == '0);

endmodule
`endif

// File: rtl/move_sequencer.sv
// Plays a packed move list out to the motor driver one move at a time.
// Define MOVE_SETTLE_EN to add a SETTLE_CYCLES settle period after every completed move.
module move_sequencer
    import rbot_move_defs::*;
#(
    parameter int unsigned NUM_SLOTS     = 50,
    parameter int unsigned SETTLE_CYCLES = 1_000_000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        new_moves,
    input  logic [CODE_W*NUM_SLOTS-1:0] moves,
    move_sequencer_if.master            motor,
    output logic                        busy,
    output logic                        seq_done,
    output logic [5:0]                  move_count,
    output logic                        drop_err,
    output logic                        bad_code
);

    localparam int unsigned VEC_W  = CODE_W * NUM_SLOTS;
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS + 1);

    if ((NUM_SLOTS < 2) || (NUM_SLOTS > 63)) begin : g_bad_num_slots
        $error("move_sequencer: NUM_SLOTS must be in 2..63");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
        $error("move_sequencer: SETTLE_CYCLES must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [VEC_W-1:0]  shreg_q, shreg_d;
    logic [SLOT_W-1:0] slots_left_q, slots_left_d;
    logic [5:0]        move_count_q, move_count_d;
    logic              drop_err_q, drop_err_d;
    logic              bad_code_q, bad_code_d;

    logic [CODE_W-1:0] top_code;
    logic [VEC_W-1:0]  shreg_shifted;
    logic              settle_expired;

    assign top_code      = shreg_q[VEC_W-1 -: CODE_W];
    assign shreg_shifted = {shreg_q[VEC_W-CODE_W-1:0], {CODE_W{1'b0}}};

`ifdef MOVE_SETTLE_EN
    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    ((state_q == ST_WAIT_DONE) && motor.motor_done),
        .enable  (state_q == ST_SETTLE),
        .expired (settle_expired)
    );
`else
    assign settle_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        slots_left_d = slots_left_q;
        move_count_d = move_count_q;
        drop_err_d   = drop_err_q;
        bad_code_d   = bad_code_q;

        // Any list offered outside IDLE is discarded and remembered.
        if (new_moves && (state_q != ST_IDLE)) begin
            drop_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (new_moves) begin
                    shreg_d      = moves;
                    slots_left_d = SLOT_W'(NUM_SLOTS);
                    move_count_d = '0;
                    state_d      = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if ((shreg_q == '0) || (slots_left_q == '0)) begin
                    state_d = ST_DONE;
                end else if (!is_legal_code(top_code)) begin
                    shreg_d      = shreg_shifted;
                    slots_left_d = slots_left_q - SLOT_W'(1);
                    if (top_code != MOVE_NOP) begin
                        bad_code_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (motor.move_ready) begin
                    shreg_d      = shreg_shifted;
                    slots_left_d = slots_left_q - SLOT_W'(1);
                    if (move_count_q != 6'(NUM_SLOTS)) begin
                        move_count_d = move_count_q + 6'd1;
                    end
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (motor.motor_done) begin
`ifdef MOVE_SETTLE_EN
                    state_d = ST_SETTLE;
`else
                    state_d = ST_ALIGN;
`endif
                end
            end
            ST_SETTLE: begin
                if (settle_expired) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            slots_left_q <= '0;
            move_count_q <= '0;
            drop_err_q   <= 1'b0;
            bad_code_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            slots_left_q <= slots_left_d;
            move_count_q <= move_count_d;
            drop_err_q   <= drop_err_d;
            bad_code_q   <= bad_code_d;
        end
    end

    assign motor.move_valid = (state_q == ST_ISSUE);
    assign motor.move_code  = (state_q == ST_ISSUE) ? top_code : MOVE_NOP;
    assign busy             = (state_q != ST_IDLE);
    assign seq_done         = (state_q == ST_DONE);
    assign move_count       = move_count_q;
    assign drop_err         = drop_err_q;
    assign bad_code         = bad_code_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: list playback, backpressure, empty list, illegal codes,
// dropped lists, mid-sequence reset and post-move latency (with or without MOVE_SETTLE_EN).
module tb_move_sequencer;

    localparam int unsigned NUM_SLOTS = 50;
`ifdef MOVE_SETTLE_EN
    localparam int S = 8;
`else
    localparam int S = 0;
`endif

    logic         clock = 1'b0;
    logic         reset_n;
    logic         new_moves;
    logic [199:0] moves;
    logic         busy;
    logic         seq_done;
    logic [5:0]   move_count;
    logic         drop_err;
    logic         bad_code;

    int errors = 0;
    int checks = 0;
    int waited;
    logic [199:0] m;

    move_sequencer_if mif ();

    move_sequencer #(
        .NUM_SLOTS     (NUM_SLOTS),
        .SETTLE_CYCLES (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .new_moves  (new_moves),
        .moves      (moves),
        .motor      (mif),
        .busy       (busy),
        .seq_done   (seq_done),
        .move_count (move_count),
        .drop_err   (drop_err),
        .bad_code   (bad_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [199:0] list);
        moves     = list;
        new_moves = 1'b1;
        @(negedge clock);
        new_moves = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while ((mif.move_valid !== 1'b1) && (n < 300)) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " valid seen"}, 32'(mif.move_valid), 1);
    endtask

    task automatic wait_seq_done(input string tag);
        int n;
        n = 0;
        while ((seq_done !== 1'b1) && (n < 300)) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " seq_done seen"}, 32'(seq_done), 1);
    endtask

    // Expects move_ready high; returns at the negedge just after motor_done was sampled.
    task automatic do_move(input string tag, input logic [3:0] code, input int dly, output int n);
        wait_valid(tag, n);
        chk({tag, " code"}, 32'(mif.move_code), 32'(code));
        @(negedge clock);
        chk({tag, " valid drop"}, 32'(mif.move_valid), 0);
        repeat (dly - 1) @(negedge clock);
        mif.motor_done = 1'b1;
        @(negedge clock);
        mif.motor_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        new_moves      = 1'b0;
        moves          = '0;
        mif.move_ready = 1'b0;
        mif.motor_done = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset valid", 32'(mif.move_valid), 0);
        chk("reset code", 32'(mif.move_code), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset seq_done", 32'(seq_done), 0);
        chk("reset count", 32'(move_count), 0);
        chk("reset drop_err", 32'(drop_err), 0);
        chk("reset bad_code", 32'(bad_code), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: R Li Di F right-aligned, done 3 cycles after each accept
        mif.move_ready = 1'b1;
        strobe(200'h29D6);
        do_move("t1 m0", 4'd2, 3, waited);
        do_move("t1 m1", 4'd9, 3, waited);
        do_move("t1 m2", 4'd13, 3, waited);
        do_move("t1 m3", 4'd6, 3, waited);
        chk("t1 seq_done early", 32'(seq_done), 0);
        chk("t1 busy", 32'(busy), 1);
        repeat (S) @(negedge clock);
        @(negedge clock);
        chk("t1 seq_done", 32'(seq_done), 1);
        chk("t1 count", 32'(move_count), 4);
        @(negedge clock);
        chk("t1 seq_done pulse", 32'(seq_done), 0);
        chk("t1 busy low", 32'(busy), 0);

        // 2: backpressure with a stray motor_done while stalled in ISSUE
        mif.move_ready = 1'b0;
        strobe(200'h6);
        wait_valid("t2", waited);
        for (int i = 0; i < 11; i++) begin
            chk("t2 stall valid", 32'(mif.move_valid), 1);
            chk("t2 stall code", 32'(mif.move_code), 6);
            chk("t2 stall count", 32'(move_count), 0);
            mif.motor_done = (i == 4);
            @(negedge clock);
        end
        mif.motor_done = 1'b0;
        chk("t2 last stall valid", 32'(mif.move_valid), 1);
        mif.move_ready = 1'b1;
        @(negedge clock);
        chk("t2 valid after xfer", 32'(mif.move_valid), 0);
        chk("t2 count", 32'(move_count), 1);
        mif.motor_done = 1'b1;
        @(negedge clock);
        mif.motor_done = 1'b0;
        wait_seq_done("t2");
        chk("t2 final count", 32'(move_count), 1);
        @(negedge clock);

        // 3: empty list
        strobe('0);
        chk("t3 valid a", 32'(mif.move_valid), 0);
        chk("t3 seq_done a", 32'(seq_done), 0);
        chk("t3 busy", 32'(busy), 1);
        @(negedge clock);
        chk("t3 seq_done", 32'(seq_done), 1);
        chk("t3 valid b", 32'(mif.move_valid), 0);
        chk("t3 count", 32'(move_count), 0);
        chk("t3 bad_code", 32'(bad_code), 0);
        @(negedge clock);
        chk("t3 idle", 32'(busy), 0);

        // 4: U, illegal 15, Ui
        strobe(200'h4F5);
        do_move("t4 m0", 4'd4, 1, waited);
        do_move("t4 m1", 4'd5, 1, waited);
        wait_seq_done("t4");
        chk("t4 bad_code", 32'(bad_code), 1);
        chk("t4 count", 32'(move_count), 2);
        @(negedge clock);

        // 5a: top-slot latency, then a list dropped during WAIT_DONE
        m = '0;
        m[199:192] = 8'h23;
        strobe(m);
        chk("t5 valid latency1", 32'(mif.move_valid), 0);
        @(negedge clock);
        chk("t5 valid latency2", 32'(mif.move_valid), 1);
        chk("t5 code0", 32'(mif.move_code), 2);
        @(negedge clock);
        strobe(200'hC);
        chk("t5 drop_err", 32'(drop_err), 1);
        chk("t5 busy", 32'(busy), 1);
        chk("t5 no valid in wait", 32'(mif.move_valid), 0);
        mif.motor_done = 1'b1;
        @(negedge clock);
        mif.motor_done = 1'b0;
        do_move("t5 m1", 4'd3, 1, waited);
        chk("t5 done-to-valid gap", 32'(waited), 32'(1 + S));
        wait_seq_done("t5");
        chk("t5 count", 32'(move_count), 2);
        chk("t5 drop_err sticky", 32'(drop_err), 1);
        @(negedge clock);

        // 5b: asynchronous reset in WAIT_DONE, then a fresh list
        m = '0;
        m[199:192] = 8'h89;
        strobe(m);
        wait_valid("t5r", waited);
        chk("t5r code", 32'(mif.move_code), 8);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("t5r busy", 32'(busy), 0);
        chk("t5r valid", 32'(mif.move_valid), 0);
        chk("t5r count", 32'(move_count), 0);
        chk("t5r drop_err", 32'(drop_err), 0);
        chk("t5r bad_code", 32'(bad_code), 0);
        chk("t5r seq_done", 32'(seq_done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        strobe(200'hB);
        do_move("t5r m0", 4'd11, 2, waited);
        wait_seq_done("t5r");
        chk("t5r final count", 32'(move_count), 1);
        chk("t5r final drop_err", 32'(drop_err), 0);
        @(negedge clock);
        chk("t5r idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
